pcie_tcap_hdrgen: RTL and testbench

- Multi-channel generator for PCIe TLP capture headers.
- Header layout per channel: direction, reserved/flags, sequence.
- Each capture channel (one per TLP direction/source) requests a header. The block arbitrates round-robin, stamps a per-channel wrapping sequence number, and flags sequence gaps caused by upstream drops.
- Sits between the TLP tap FIFOs and the Ethernet encapsulation stage. The registered header is consumed through a valid/ready handshake.

---
 rtl/pcie_tcap_hdrgen.sv | 141 ++++++++++++++
 tb/tb_pcie_tcap_hdrgen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tcap_hdrgen.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tcap_hdrgen
// Brief    : Round-robin PCIe TLP capture header generator with per-channel
//            wrapping sequence numbers and upstream-drop gap flags.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tcap_hdrgen #(
    parameter int NUM_CH = 2,
    parameter int DIR_W  = 2,
    parameter int RSRV_W = 14,
    parameter int SEQ_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_valid,
    output logic [NUM_CH-1:0] in_ready,
    input  logic [NUM_CH-1:0] in_drop,
    input  logic              seq_clear,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [DIR_W-1:0]  hdr_dir,
    output logic [RSRV_W-1:0] hdr_rsrv,
    output logic [SEQ_W-1:0]  hdr_seq
);

    localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [SEQ_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_CH-1:0]  r_gap;
    logic               r_hdr_valid;
    logic [DIR_W-1:0]   r_hdr_dir;
    logic [RSRV_W-1:0]  r_hdr_rsrv;
    logic [SEQ_W-1:0]   r_hdr_seq;

    logic [NUM_CH-1:0]  w_grant;
    logic [c_PTR_W-1:0] w_gidx;
    logic               w_found;
    int                 w_c;
    logic               w_free;
    logic [NUM_CH-1:0]  w_acc;
    logic               w_any;
    logic [SEQ_W-1:0]   w_sel_cnt;
    logic               w_sel_gap;

    // Search upward from the round-robin pointer, wrapping to channel 0.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_c = int'(r_ptr) + k;
            if (w_c >= NUM_CH) begin
                w_c = w_c - NUM_CH;
            end
            if (!w_found && in_valid[w_c]) begin
                w_found      = 1'b1;
                w_grant[w_c] = 1'b1;
                w_gidx       = c_PTR_W'(w_c);
            end
        end
    end

    assign w_free   = !r_hdr_valid || hdr_ready;
    assign in_ready = w_grant & {NUM_CH{w_free}};
    assign w_acc    = in_ready;
    assign w_any    = |w_acc;

    always_comb begin
        w_sel_cnt = '0;
        w_sel_gap = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_cnt = r_cnt[i];
                w_sel_gap = r_gap[i];
            end
        end
    end

    // Clear wins over both increment sources; a drop coinciding with an
    // accept belongs to the following TLP, so the gap flag survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_gap <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (seq_clear) begin
                    r_cnt[i] <= '0;
                    r_gap[i] <= 1'b0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + SEQ_W'(w_acc[i]) + SEQ_W'(in_drop[i]);
                    if (in_drop[i]) begin
                        r_gap[i] <= 1'b1;
                    end else if (w_acc[i]) begin
                        r_gap[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (int'(w_gidx) == NUM_CH - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gidx + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_valid <= 1'b0;
            r_hdr_dir   <= '0;
            r_hdr_rsrv  <= '0;
            r_hdr_seq   <= '0;
        end else if (w_any) begin
            r_hdr_valid <= 1'b1;
            r_hdr_dir   <= DIR_W'(w_gidx);
            r_hdr_rsrv  <= RSRV_W'(w_sel_gap);
            r_hdr_seq   <= w_sel_cnt;
        end else if (hdr_ready) begin
            r_hdr_valid <= 1'b0;
        end
    end

    assign hdr_valid = r_hdr_valid;
    assign hdr_dir   = r_hdr_dir;
    assign hdr_rsrv  = r_hdr_rsrv;
    assign hdr_seq   = r_hdr_seq;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tcap_hdrgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_tcap_hdrgen
// Brief    : Directed + randomized bench for pcie_tcap_hdrgen (3 ch, 8-bit seq).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tcap_hdrgen;

    localparam int NCH = 3;
    localparam int DW  = 2;
    localparam int RW  = 14;
    localparam int SW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] in_valid = '0;
    logic [NCH-1:0] in_ready;
    logic [NCH-1:0] in_drop = '0;
    logic           seq_clear = 1'b0;
    logic           hdr_valid;
    logic           hdr_ready = 1'b0;
    logic [DW-1:0]  hdr_dir;
    logic [RW-1:0]  hdr_rsrv;
    logic [SW-1:0]  hdr_seq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_tcap_hdrgen #(
        .NUM_CH(NCH),
        .DIR_W (DW),
        .RSRV_W(RW),
        .SEQ_W (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_drop  (in_drop),
        .seq_clear(seq_clear),
        .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready),
        .hdr_dir  (hdr_dir),
        .hdr_rsrv (hdr_rsrv),
        .hdr_seq  (hdr_seq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic m_hv;
    int   m_dir, m_seq, m_gap_h, m_ptr;
    int   m_cnt [NCH];
    bit   m_gap [NCH];

    function automatic int grant_of();
        if (m_hv && !hdr_ready) return -1;
        for (int k = 0; k < NCH; k++) begin
            if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_ready();
        logic [NCH-1:0] r;
        r = '0;
        if (grant_of() >= 0) r[grant_of()] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hv <= 1'b0; m_dir <= 0; m_seq <= 0; m_gap_h <= 0; m_ptr <= 0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] <= 0;
                m_gap[i] <= 1'b0;
            end
        end else begin
            if (grant_of() >= 0) begin
                m_hv    <= 1'b1;
                m_dir   <= grant_of();
                m_seq   <= m_cnt[grant_of()];
                m_gap_h <= int'(m_gap[grant_of()]);
                m_ptr   <= (grant_of() + 1) % NCH;
            end else if (hdr_ready) begin
                m_hv <= 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (seq_clear) begin
                    m_cnt[i] <= 0;
                    m_gap[i] <= 1'b0;
                end else begin
                    m_cnt[i] <= (m_cnt[i] + int'(grant_of() == i) + int'(in_drop[i])) % (1 << SW);
                    m_gap[i] <= in_drop[i] ? 1'b1 : ((grant_of() == i) ? 1'b0 : m_gap[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("hdr_valid", 32'(hdr_valid), 32'(m_hv));
            if (m_hv) begin
                chk("hdr_dir", 32'(hdr_dir), m_dir);
                chk("hdr_seq", 32'(hdr_seq), m_seq);
                chk("hdr_rsrv", 32'(hdr_rsrv), m_gap_h);
            end
        end
    end

    // Consumed-header log used by the directed literal checks.
    logic [10:0] q[$];
    always @(negedge clk) begin
        if (!rst && hdr_valid && hdr_ready) q.push_back({hdr_dir, hdr_rsrv[0], hdr_seq});
    end

    task automatic chkh(input string name, input int idx, input int dir, input int seq, input int gap);
        logic [10:0] e;
        e = {2'(dir), 1'(gap), 8'(seq)};
        if (idx >= q.size()) begin
            checks++;
            failures++;
            $display("FAIL %s actual=missing required=%0h", name, e);
        end else begin
            chk(name, 32'(q[idx]), 32'(e));
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] v, input logic [NCH-1:0] d, input logic clr, input logic rdy);
        in_valid  = v;
        in_drop   = d;
        seq_clear = clr;
        hdr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0; in_drop = '0; seq_clear = 1'b0; hdr_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_valid", 32'(hdr_valid), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_seq", 32'(hdr_seq), 0);
        chk("rst_dir", 32'(hdr_dir), 0);
        chk("rst_rsrv", 32'(hdr_rsrv), 0);

        // Single channel streaming
        repeat (3) cyc(3'b001, 3'b000, 1'b0, 1'b1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);
        chk("t1_count", q.size(), 3);
        chkh("t1_h0", 0, 0, 0, 0);
        chkh("t1_h1", 1, 0, 1, 0);
        chkh("t1_h2", 2, 0, 2, 0);

        // Two channels alternating
        do_reset();
        repeat (4) cyc(3'b011, 3'b000, 1'b0, 1'b1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);
        chk("t2_count", q.size(), 4);
        chkh("t2_h0", 0, 0, 0, 0);
        chkh("t2_h1", 1, 1, 0, 0);
        chkh("t2_h2", 2, 0, 1, 0);
        chkh("t2_h3", 3, 1, 1, 0);

        // Backpressure holds header and stalls counters
        do_reset();
        in_valid = 3'b001; hdr_ready = 1'b1;
        #1;
        chk("t3_comb_ready", 32'(in_ready), 1);
        cyc(3'b001, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 3'b001; hdr_ready = 1'b0;
            #1;
            chk("t3_stall_ready", 32'(in_ready), 0);
            chk("t3_stall_valid", 32'(hdr_valid), 1);
            chk("t3_stall_seq", 32'(hdr_seq), 0);
            @(posedge clk);
            #1;
        end
        cyc(3'b001, 3'b000, 1'b0, 1'b1);
        chk("t3_next_valid", 32'(hdr_valid), 1);
        chk("t3_next_seq", 32'(hdr_seq), 1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);

        // Drop gaps
        do_reset();
        repeat (2) cyc(3'b000, 3'b010, 1'b0, 1'b1);
        cyc(3'b010, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b0, 1'b1);
        cyc(3'b010, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b010, 1'b0, 1'b1);
        cyc(3'b010, 3'b010, 1'b0, 1'b1);
        cyc(3'b010, 3'b000, 1'b0, 1'b1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);
        chk("t4_count", q.size(), 4);
        chkh("t4_h0", 0, 1, 2, 1);
        chkh("t4_h1", 1, 1, 3, 0);
        chkh("t4_h2", 2, 1, 5, 1);
        chkh("t4_h3", 3, 1, 7, 1);

        // Counter wrap and clear with concurrent accept
        do_reset();
        repeat (255) cyc(3'b000, 3'b001, 1'b0, 1'b1);
        repeat (2) cyc(3'b001, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b0, 1'b1);
        repeat (8) cyc(3'b000, 3'b001, 1'b0, 1'b1);
        cyc(3'b001, 3'b000, 1'b1, 1'b1);
        cyc(3'b001, 3'b000, 1'b0, 1'b1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);
        chk("t5_count", q.size(), 4);
        chkh("t5_h0", 0, 0, 255, 1);
        chkh("t5_h1", 1, 0, 0, 0);
        chkh("t5_h2", 2, 0, 9, 1);
        chkh("t5_h3", 3, 0, 0, 0);

        // Asynchronous reset mid-transfer
        do_reset();
        cyc(3'b011, 3'b000, 1'b0, 1'b0);
        cyc(3'b011, 3'b000, 1'b0, 1'b0);
        chk("t6_pre_valid", 32'(hdr_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(hdr_valid), 0);
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        cyc(3'b001, 3'b000, 1'b0, 1'b1);
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);
        chk("t6_count", q.size(), 1);
        chkh("t6_h0", 0, 0, 0, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(NCH'($urandom), NCH'($urandom & $urandom),
                ($urandom % 64) == 0, ($urandom % 4) != 0);
        end
        repeat (2) cyc(3'b000, 3'b000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
